mod_ptr_counter: RTL

Parametrised modulo-DEPTH up/down pointer counter with variable step, synchronous clear, load and a wrap-phase bit. It is the next generation of the team's loadable binary counter: it supports non-power-of-two depths, steps of 0..MAX_STEP per cycle in both directions, and wrap signalling. It sits in the fetch queue as the read/write pointer generator, so multi-entry push/pop and full/empty detection via the phase bit are handled here rather than in the queue control.

---
 rtl/ptr_cnt_pkg.sv | 27 ++
 rtl/mod_step_calc.sv | 43 ++++
 rtl/mod_ptr_counter.sv | 114 +++++++++++
 3 files changed

// File: rtl/ptr_cnt_pkg.sv
// Shared types and elaboration helpers for the modulo pointer counter family.
// Used by mod_ptr_counter, mod_step_calc and the fetch-queue look-ahead logic.
package ptr_cnt_pkg;

  // Decoded per-cycle operation, in priority order clr > ld > step > hold.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LD,
    OP_STEP,
    OP_LDERR
  } ptr_op_e;

  // Width of a step field able to carry 0..max_step.
  function automatic int calc_sw(input int max_step);
    return $clog2(max_step + 1);
  endfunction

  function automatic bit depth_fits(input int dw, input int depth);
    return depth <= (1 << dw);
  endfunction

  function automatic bit step_fits(input int depth, input int max_step);
    return (max_step >= 1) && (max_step <= depth);
  endfunction

endpackage

// File: rtl/mod_step_calc.sv
// Combinational modulo-DEPTH step: next = (count + s_up - s_dn) mod DEPTH.
// Flags a wrap whenever the raw sum leaves 0..DEPTH-1 in either direction.
module mod_step_calc
  import ptr_cnt_pkg::*;
#(
  parameter int DW    = 4,
  parameter int DEPTH = 12,
  parameter int SW    = 3
) (
  input  logic [DW-1:0] count,
  input  logic [SW-1:0] s_up,
  input  logic [SW-1:0] s_dn,
  output logic [DW-1:0] next_count,
  output logic          wrapped
);

  localparam int                    PAD      = DW + 2 - SW;
  localparam logic signed [DW+1:0]  DEPTH_S  = (DW+2)'(DEPTH);
  localparam logic        [DW-1:0]  DEPTH_LO = DW'(DEPTH);

  logic signed [DW+1:0] sum;

  // Two extra bits hold count+MAX_STEP (< 2**(DW+1)) and the sign of count-MAX_STEP.
  assign sum = $signed({2'b00, count})
             + $signed({{PAD{1'b0}}, s_up})
             - $signed({{PAD{1'b0}}, s_dn});

  // The corrected result always fits in DW bits, so mod-2**DW arithmetic on the
  // low bits is exact; this also covers DEPTH == 2**DW where DEPTH_LO is zero.
  always_comb begin
    // NOTE: every output gets a default before the branches so no latch is inferred.
    next_count = sum[DW-1:0];
    wrapped    = 1'b0;
    if (sum[DW+1]) begin
      next_count = sum[DW-1:0] + DEPTH_LO;
      wrapped    = 1'b1;
    end else if (sum >= DEPTH_S) begin
      next_count = sum[DW-1:0] - DEPTH_LO;
      wrapped    = 1'b1;
    end
  end

endmodule

// File: rtl/mod_ptr_counter.sv
// Modulo-DEPTH up/down pointer counter with saturating variable step, clear,
// checked load and a phase bit that toggles on every wrap (full/empty tiebreak).
module mod_ptr_counter
  import ptr_cnt_pkg::*;
#(
  parameter int DW       = 4,
  parameter int DEPTH    = 12,
  parameter int MAX_STEP = 4,
  parameter int SW       = calc_sw(MAX_STEP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          ld,
  input  logic [DW-1:0] ld_val,
  input  logic          ld_phase,
  input  logic          inc,
  input  logic [SW-1:0] inc_step,
  input  logic          dec,
  input  logic [SW-1:0] dec_step,
  output logic [DW-1:0] count,
  output logic          phase,
  output logic          wrap,
  output logic          ld_err
);

  if (DEPTH < 2) begin : g_chk_depth_min
    $error("mod_ptr_counter: DEPTH must be at least 2");
  end
  if (!depth_fits(DW, DEPTH)) begin : g_chk_depth_fit
    $error("mod_ptr_counter: DEPTH-1 does not fit in DW bits");
  end
  if (!step_fits(DEPTH, MAX_STEP)) begin : g_chk_step
    $error("mod_ptr_counter: MAX_STEP must be in 1..DEPTH");
  end

  localparam logic [DW:0]   DEPTH_W    = (DW+1)'(DEPTH);
  localparam logic [SW-1:0] MAX_STEP_W = SW'(MAX_STEP);

  ptr_op_e       op;
  logic [SW-1:0] s_up;
  logic [SW-1:0] s_dn;
  logic [DW-1:0] next_count;
  logic          wrapped;

  // Oversized step requests clamp to MAX_STEP rather than being rejected.
  always_comb begin
    s_up = '0;
    s_dn = '0;
    if (inc) s_up = (inc_step > MAX_STEP_W) ? MAX_STEP_W : inc_step;
    if (dec) s_dn = (dec_step > MAX_STEP_W) ? MAX_STEP_W : dec_step;
  end

  // A rejected load still owns the cycle: pending inc/dec are dropped with it.
  always_comb begin
    op = OP_HOLD;
    if (clr) begin
      op = OP_CLR;
    end else if (ld) begin
      op = ({1'b0, ld_val} < DEPTH_W) ? OP_LD : OP_LDERR;
    end else if (inc || dec) begin
      op = OP_STEP;
    end
  end

  mod_step_calc #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .SW    (SW)
  ) u_step_calc (
    .count      (count),
    .s_up       (s_up),
    .s_dn       (s_dn),
    .next_count (next_count),
    .wrapped    (wrapped)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      phase  <= 1'b0;
      wrap   <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      wrap   <= 1'b0;
      ld_err <= 1'b0;
      case (op)
        OP_CLR: begin
          count <= '0;
          phase <= 1'b0;
        end
        OP_LD: begin
          count <= ld_val;
          phase <= ld_phase;
        end
        OP_LDERR: ld_err <= 1'b1;
        OP_STEP: begin
          count <= next_count;
          wrap  <= wrapped;
          if (wrapped) phase <= ~phase;
        end
        default: ;
      endcase
    end
  end

  a_count_range: assert property (@(posedge clk) disable iff (!rst)
    {1'b0, count} < DEPTH_W);

  a_wrap_phase: assert property (@(posedge clk) disable iff (!rst)
    wrap |-> (phase != $past(phase)));

endmodule
